// File: rtl/joy_pkg.sv
// joy_pkg: shared definitions for the joystick conditioning path.
//   - Bit positions of the 16-bit active-high joystick vector.
//   - SOCD "last pressed" encoding and the helpers that update and apply it.
//   - Packing of a joystick vector into the Neo Geo controller byte order.
package joy_pkg;

  localparam int JB_RIGHT  = 0;
  localparam int JB_LEFT   = 1;
  localparam int JB_DOWN   = 2;
  localparam int JB_UP     = 3;
  localparam int JB_A      = 4;
  localparam int JB_B      = 5;
  localparam int JB_C      = 6;
  localparam int JB_D      = 7;
  localparam int JB_E      = 8;
  localparam int JB_F      = 9;
  localparam int JB_START  = 10;
  localparam int JB_SELECT = 11;

  // Number of meaningful bits in a joystick vector (15:12 are unused).
  localparam int JOY_W = 12;

  // Per-axis record of the direction that was pressed most recently.
  // NEG = Left / Down, POS = Right / Up.
  typedef enum logic [1:0] {
    LAST_NONE = 2'd0,
    LAST_NEG  = 2'd1,
    LAST_POS  = 2'd2
  } socd_last_e;

  // Update of the per-axis "last" record from the rising edges of the
  // debounced direction bits. A simultaneous rise is ambiguous -> NONE.
  function automatic socd_last_e socd_last_next(input socd_last_e cur,
                                                input logic       neg_rise,
                                                input logic       pos_rise);
    socd_last_e nxt;
    nxt = cur;
    if (neg_rise && pos_rise) nxt = LAST_NONE;
    else if (pos_rise)        nxt = LAST_POS;
    else if (neg_rise)        nxt = LAST_NEG;
    return nxt;
  endfunction

  // Resolve one axis. Returns {neg, pos}.
  // mode 0: both held -> neutral. mode 1: both held -> last wins (NONE -> neutral).
  function automatic logic [1:0] socd_resolve(input logic       mode,
                                              input socd_last_e last,
                                              input logic       neg,
                                              input logic       pos);
    logic [1:0] res;
    res = {neg, pos};
    if (neg && pos) begin
      if (!mode)                res = 2'b00;
      else if (last == LAST_POS) res = 2'b01;
      else if (last == LAST_NEG) res = 2'b10;
      else                      res = 2'b00;
    end
    return res;
  endfunction

  // Neo Geo byte order (active-high here, inverted by the caller):
  // bit0 Up, 1 Down, 2 Left, 3 Right, 4 A, 5 B, 6 C, 7 D.
  function automatic logic [7:0] neo_pack(input logic [JOY_W-1:0] j);
    return {j[JB_D], j[JB_C], j[JB_B], j[JB_A],
            j[JB_RIGHT], j[JB_LEFT], j[JB_DOWN], j[JB_UP]};
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// joy_debounce: 2-flop synchronizer followed by a whole-vector debouncer.
// The vector is accepted into "stable" only after the synchronized value has
// stayed unchanged for STABLE_CYCLES consecutive clk cycles.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high
//   din     in  WIDTH  raw vector, asynchronous to clk
//   stable  out WIDTH  debounced vector
module joy_debounce
  import joy_pkg::*;
#(
  parameter int WIDTH         = JOY_W,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] prev;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      prev   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
      if (s2 != prev) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Counter saturates here; it never wraps.
        stable <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/joy_db15_cond.sv
// joy_db15_cond: conditions the two DB15 joystick vectors for the core.
//   sync + debounce (joy_debounce x2) -> SOCD resolution -> autofire ->
//   registered outputs (active-high vectors and active-low Neo Geo fields).
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   joy1_in, joy2_in      16-bit active-high raw vectors (async to clk)
//   socd_mode             0 = neutral, 1 = last-input-wins
//   af_mask1, af_mask2    autofire enables for A..D (bit0 = A)
//   joy1_out, joy2_out    cleaned vectors, bits 15:12 forced to 0
//   neo_p1_n, neo_p2_n    active-low Up,Down,Left,Right,A,B,C,D
//   neo_start_n           active-low Start, bit0 = P1
//   neo_select_n          active-low Select, bit0 = P1
//   change                one-cycle pulse when either cleaned vector changes
module joy_db15_cond
  import joy_pkg::*;
#(
  parameter int STABLE_CYCLES  = 1024,
  parameter int AF_HALF_PERIOD = 400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] joy1_in,
  input  logic [15:0] joy2_in,
  input  logic        socd_mode,
  input  logic [3:0]  af_mask1,
  input  logic [3:0]  af_mask2,
  output logic [15:0] joy1_out,
  output logic [15:0] joy2_out,
  output logic [7:0]  neo_p1_n,
  output logic [7:0]  neo_p2_n,
  output logic [1:0]  neo_start_n,
  output logic [1:0]  neo_select_n,
  output logic        change
);

  localparam int AW = $clog2(AF_HALF_PERIOD);
  localparam logic [AW-1:0] AF_MAX = AW'(AF_HALF_PERIOD - 1);

  // Upper nibbles carry nothing downstream.
  logic unused_hi;
  assign unused_hi = ^{joy1_in[15:12], joy2_in[15:12]};

  logic [JOY_W-1:0] stab     [2];
  logic [JOY_W-1:0] stab_q   [2];
  logic [JOY_W-1:0] rise     [2];
  logic [JOY_W-1:0] clean    [2];
  logic [3:0]       af_mask  [2];
  socd_last_e       last_h     [2];
  socd_last_e       last_v     [2];
  socd_last_e       last_h_nxt [2];
  socd_last_e       last_v_nxt [2];

  logic [AW-1:0] af_cnt;
  logic          af_phase;

  joy_debounce #(.WIDTH(JOY_W), .STABLE_CYCLES(STABLE_CYCLES)) u_deb1 (
    .clk    (clk),
    .reset  (reset),
    .din    (joy1_in[JOY_W-1:0]),
    .stable (stab[0])
  );

  joy_debounce #(.WIDTH(JOY_W), .STABLE_CYCLES(STABLE_CYCLES)) u_deb2 (
    .clk    (clk),
    .reset  (reset),
    .din    (joy2_in[JOY_W-1:0]),
    .stable (stab[1])
  );

  assign af_mask[0] = af_mask1;
  assign af_mask[1] = af_mask2;
  assign rise[0]    = stab[0] & ~stab_q[0];
  assign rise[1]    = stab[1] & ~stab_q[1];

  // SOCD and autofire. The "last" update is used in the same cycle as the
  // rising edge so that resolution adds no latency after "stable".
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      last_h_nxt[p] = socd_last_next(last_h[p], rise[p][JB_LEFT], rise[p][JB_RIGHT]);
      last_v_nxt[p] = socd_last_next(last_v[p], rise[p][JB_DOWN], rise[p][JB_UP]);
      clean[p] = stab[p];
      {clean[p][JB_LEFT], clean[p][JB_RIGHT]} =
        socd_resolve(socd_mode, last_h_nxt[p], stab[p][JB_LEFT], stab[p][JB_RIGHT]);
      {clean[p][JB_DOWN], clean[p][JB_UP]} =
        socd_resolve(socd_mode, last_v_nxt[p], stab[p][JB_DOWN], stab[p][JB_UP]);
      for (int i = 0; i < 4; i++) begin
        if (af_mask[p][i]) clean[p][JB_A+i] = stab[p][JB_A+i] & af_phase;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        stab_q[p] <= '0;
        last_h[p] <= LAST_NONE;
        last_v[p] <= LAST_NONE;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        stab_q[p] <= stab[p];
        last_h[p] <= last_h_nxt[p];
        last_v[p] <= last_v_nxt[p];
      end
    end
  end

  // Free-running autofire phase shared by both players.
  always_ff @(posedge clk) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AF_MAX) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + 1'b1;
    end
  end

  logic [15:0] joy1_nxt;
  logic [15:0] joy2_nxt;
  assign joy1_nxt = {4'b0000, clean[0]};
  assign joy2_nxt = {4'b0000, clean[1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      joy1_out     <= 16'h0000;
      joy2_out     <= 16'h0000;
      neo_p1_n     <= 8'hFF;
      neo_p2_n     <= 8'hFF;
      neo_start_n  <= 2'b11;
      neo_select_n <= 2'b11;
      change       <= 1'b0;
    end else begin
      joy1_out     <= joy1_nxt;
      joy2_out     <= joy2_nxt;
      neo_p1_n     <= ~neo_pack(clean[0]);
      neo_p2_n     <= ~neo_pack(clean[1]);
      neo_start_n  <= ~{clean[1][JB_START], clean[0][JB_START]};
      neo_select_n <= ~{clean[1][JB_SELECT], clean[0][JB_SELECT]};
      change       <= ({joy1_nxt, joy2_nxt} != {joy1_out, joy2_out});
    end
  end

endmodule

// File: tb/tb_joy_db15_cond.sv
module tb_joy_db15_cond;

  localparam int SC = 8;
  localparam int AF = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] joy1_in, joy2_in;
  logic        socd_mode;
  logic [3:0]  af_mask1, af_mask2;
  logic [15:0] joy1_out, joy2_out;
  logic [7:0]  neo_p1_n, neo_p2_n;
  logic [1:0]  neo_start_n, neo_select_n;
  logic        change;

  always #5 clk = ~clk;

  joy_db15_cond #(.STABLE_CYCLES(SC), .AF_HALF_PERIOD(AF)) dut (
    .clk          (clk),
    .reset        (reset),
    .joy1_in      (joy1_in),
    .joy2_in      (joy2_in),
    .socd_mode    (socd_mode),
    .af_mask1     (af_mask1),
    .af_mask2     (af_mask2),
    .joy1_out     (joy1_out),
    .joy2_out     (joy2_out),
    .neo_p1_n     (neo_p1_n),
    .neo_p2_n     (neo_p2_n),
    .neo_start_n  (neo_start_n),
    .neo_select_n (neo_select_n),
    .change       (change)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock; outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_j1"},  {16'h0, joy1_out}, 32'h0);
    check({tag, "_j2"},  {16'h0, joy2_out}, 32'h0);
    check({tag, "_p1"},  {24'h0, neo_p1_n}, 32'hFF);
    check({tag, "_p2"},  {24'h0, neo_p2_n}, 32'hFF);
    check({tag, "_st"},  {30'h0, neo_start_n}, 32'h3);
    check({tag, "_sel"}, {30'h0, neo_select_n}, 32'h3);
    check({tag, "_chg"}, {31'h0, change}, 32'h0);
  endtask

  logic [15:0] acc_j2;
  logic        acc_chg;
  logic [1:0]  acc_st;
  logic        a_s [24];
  logic        b_s [24];
  logic        c_s [24];

  initial begin
    reset     = 1'b1;
    joy1_in   = 16'h0;
    joy2_in   = 16'h0;
    socd_mode = 1'b0;
    af_mask1  = 4'h0;
    af_mask2  = 4'h0;

    // Reset, quiescent inputs
    ticks(3);
    check_reset_vals("reset");
    reset = 1'b0;
    ticks(12);
    check("idle_j1", {16'h0, joy1_out}, 32'h0);

    // Debounce latency: A on P1, visible exactly at edge SC+3 = 11
    joy1_in = 16'h0010;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (e == 10) begin
        check("lat_e10_j1",  {16'h0, joy1_out}, 32'h0);
        check("lat_e10_chg", {31'h0, change}, 32'h0);
      end
      if (e == 11) begin
        check("lat_e11_j1",  {16'h0, joy1_out}, 32'h0010);
        check("lat_e11_p1",  {24'h0, neo_p1_n}, 32'hEF);
        check("lat_e11_chg", {31'h0, change}, 32'h1);
      end
      if (e == 12) begin
        check("lat_e12_j1",  {16'h0, joy1_out}, 32'h0010);
        check("lat_e12_chg", {31'h0, change}, 32'h0);
      end
    end
    joy1_in = 16'h0;
    ticks(15);
    check("lat_release_j1", {16'h0, joy1_out}, 32'h0);

    // Glitch rejection: 5-cycle Start pulse on P2
    acc_j2 = '0; acc_chg = 1'b0; acc_st = 2'b11;
    joy2_in = 16'h0400;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) joy2_in = 16'h0;
      tick();
      acc_j2  = acc_j2 | joy2_out;
      acc_chg = acc_chg | change;
      acc_st  = acc_st & neo_start_n;
    end
    check("glitch_j2",  {16'h0, acc_j2}, 32'h0);
    check("glitch_st",  {30'h0, acc_st}, 32'h3);
    check("glitch_chg", {31'h0, acc_chg}, 32'h0);

    // SOCD neutral
    socd_mode = 1'b0;
    joy1_in = 16'h0002; ticks(15);
    check("socd0_L",  {30'h0, joy1_out[1:0]}, 32'h2);
    joy1_in = 16'h0003; ticks(15);
    check("socd0_LR", {30'h0, joy1_out[1:0]}, 32'h0);
    joy1_in = 16'h000C; ticks(15);
    check("socd0_UD", {30'h0, joy1_out[3:2]}, 32'h0);
    joy1_in = 16'h0; ticks(15);

    // SOCD last-input-wins
    socd_mode = 1'b1;
    joy1_in = 16'h0002; ticks(15);
    check("socd1_L",   {30'h0, joy1_out[1:0]}, 32'h2);
    joy1_in = 16'h0003; ticks(15);
    check("socd1_LR",  {30'h0, joy1_out[1:0]}, 32'h1);
    check("socd1_LR_neo", {24'h0, neo_p1_n}, 32'hF7);
    joy1_in = 16'h0002; ticks(15);
    check("socd1_relR", {30'h0, joy1_out[1:0]}, 32'h2);
    joy1_in = 16'h0; ticks(15);
    joy1_in = 16'h0003; ticks(15);
    check("socd1_simul", {30'h0, joy1_out[1:0]}, 32'h0);
    joy1_in = 16'h0001; ticks(15);
    check("socd1_simul_relL", {30'h0, joy1_out[1:0]}, 32'h1);
    joy1_in = 16'h0008; ticks(15);
    check("socd1_U",  {30'h0, joy1_out[3:2]}, 32'h2);
    joy1_in = 16'h000C; ticks(15);
    check("socd1_UD", {30'h0, joy1_out[3:2]}, 32'h1);
    joy1_in = 16'h0; ticks(15);
    socd_mode = 1'b0;

    // Autofire on A (half period 4), B held without autofire
    af_mask1 = 4'b0001;
    joy1_in  = 16'h0030;
    ticks(15);
    for (int t = 0; t < 24; t++) begin
      tick();
      a_s[t] = joy1_out[4];
      b_s[t] = joy1_out[5];
      c_s[t] = change;
    end
    for (int t = 0; t < 20; t++) check("af_toggle", {31'h0, a_s[t+4]}, {31'h0, ~a_s[t]});
    for (int t = 0; t < 24; t++) check("af_B_held", {31'h0, b_s[t]}, 32'h1);
    for (int t = 1; t < 24; t++) check("af_change", {31'h0, c_s[t]}, {31'h0, a_s[t] != a_s[t-1]});
    joy1_in  = 16'h0;
    af_mask1 = 4'h0;
    ticks(15);
    check("af_release_j1", {16'h0, joy1_out}, 32'h0);

    // Reset mid-operation
    joy2_in = 16'h0800; ticks(15);
    check("mid_pre_j2",  {16'h0, joy2_out}, 32'h0800);
    check("mid_pre_sel", {30'h0, neo_select_n}, 32'h1);
    joy1_in = 16'h0020;
    ticks(5);
    reset = 1'b1;
    tick();
    check_reset_vals("mid_reset");
    tick();
    reset = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      tick();
      if (e == 10) begin
        check("mid_e10_j1", {16'h0, joy1_out}, 32'h0);
        check("mid_e10_j2", {16'h0, joy2_out}, 32'h0);
      end
      if (e == 11) begin
        check("mid_e11_j1",  {16'h0, joy1_out}, 32'h0020);
        check("mid_e11_j2",  {16'h0, joy2_out}, 32'h0800);
        check("mid_e11_p1",  {24'h0, neo_p1_n}, 32'hDF);
        check("mid_e11_chg", {31'h0, change}, 32'h1);
      end
      if (e == 12) check("mid_e12_chg", {31'h0, change}, 32'h0);
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
